// File: rtl/seg7_pkg.sv
// Shared definitions for the seven-segment capture block: glyph patterns,
// FSM state type and the default stability requirement.
package seg7_pkg;

  // Default number of consecutive identical samples needed to accept a digit.
  localparam int unsigned SEG7_STABLE_DEFAULT = 4;

  // Active-low glyphs, bit0 = segment a .. bit6 = segment g.
  localparam logic [6:0] GLYPH_0     = 7'b1000000;
  localparam logic [6:0] GLYPH_1     = 7'b1111001;
  localparam logic [6:0] GLYPH_2     = 7'b0100100;
  localparam logic [6:0] GLYPH_3     = 7'b0110000;
  localparam logic [6:0] GLYPH_4     = 7'b0011001;
  localparam logic [6:0] GLYPH_5     = 7'b0010010;
  localparam logic [6:0] GLYPH_6     = 7'b0000010;
  localparam logic [6:0] GLYPH_7     = 7'b1111000;
  localparam logic [6:0] GLYPH_8     = 7'b0000000;
  localparam logic [6:0] GLYPH_9     = 7'b0010000;
  localparam logic [6:0] GLYPH_A     = 7'b0001000;
  localparam logic [6:0] GLYPH_B     = 7'b0000011;
  localparam logic [6:0] GLYPH_C     = 7'b1000110;
  localparam logic [6:0] GLYPH_D     = 7'b0100001;
  localparam logic [6:0] GLYPH_E     = 7'b0000110;
  localparam logic [6:0] GLYPH_F     = 7'b0001110;
  localparam logic [6:0] GLYPH_BLANK = 7'b1111111;

  typedef enum logic [0:0] {
    StCollect,
    StOutput
  } state_e;

endpackage

// File: rtl/seg7_lookup.sv
// Combinational glyph decoder: maps an active-low segment pattern to a hex
// nibble, flagging the all-off pattern as blank and anything else unknown
// as invalid.
module seg7_lookup
  import seg7_pkg::*;
(
  input  logic [6:0] pattern,
  output logic [3:0] nibble,
  output logic       blank,
  output logic       invalid
);

  // Glyph table; blank and invalid both yield nibble 0.
  always_comb begin
    nibble  = 4'h0;
    blank   = 1'b0;
    invalid = 1'b0;
    case (pattern)
      GLYPH_0:     nibble = 4'h0;
      GLYPH_1:     nibble = 4'h1;
      GLYPH_2:     nibble = 4'h2;
      GLYPH_3:     nibble = 4'h3;
      GLYPH_4:     nibble = 4'h4;
      GLYPH_5:     nibble = 4'h5;
      GLYPH_6:     nibble = 4'h6;
      GLYPH_7:     nibble = 4'h7;
      GLYPH_8:     nibble = 4'h8;
      GLYPH_9:     nibble = 4'h9;
      GLYPH_A:     nibble = 4'hA;
      GLYPH_B:     nibble = 4'hB;
      GLYPH_C:     nibble = 4'hC;
      GLYPH_D:     nibble = 4'hD;
      GLYPH_E:     nibble = 4'hE;
      GLYPH_F:     nibble = 4'hF;
      GLYPH_BLANK: blank  = 1'b1;
      default:     invalid = 1'b1;
    endcase
  end

endmodule

// File: rtl/seg7_capture.sv
// Seven-segment display scraper. Debounces the segment bus, decodes each
// stable pattern into a hex nibble and assembles DIGITS nibbles into a frame
// that is handed off with a valid/ready handshake.
module seg7_capture
  import seg7_pkg::*;
#(
  parameter int unsigned STABLE_CYCLES = SEG7_STABLE_DEFAULT,
  parameter int unsigned DIGITS        = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [6:0]            seg_in,
  input  logic                  seg_valid,
  output logic                  seg_ready,
  output logic [4*DIGITS-1:0]   value,
  output logic [DIGITS-1:0]     blank_mask,
  output logic                  value_valid,
  input  logic                  value_ready,
  output logic                  err
);

  localparam int unsigned VW = 4 * DIGITS;
  localparam int unsigned BW = DIGITS;
  localparam int unsigned DW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  state_e            state_q, state_d;
  logic [6:0]        sample_q;
  logic [7:0]        cnt_q, cnt_d;
  logic [DW-1:0]     dcnt_q, dcnt_d;
  logic [VW-1:0]     value_q, value_d;
  logic [BW-1:0]     blank_q, blank_d;
  logic              err_q, err_d;
  logic [8:0]        run;
  logic              accept;
  logic [3:0]        lk_nibble;
  logic              lk_blank;
  logic              lk_invalid;

  seg7_lookup u_lookup (
    .pattern (seg_in),
    .nibble  (lk_nibble),
    .blank   (lk_blank),
    .invalid (lk_invalid)
  );

  // Length of the current run of valid identical samples, including this one.
  // cnt_q is zero after an invalid cycle, so a fresh run always starts at 1.
  always_comb begin
    run = 9'd0;
    if (seg_valid) begin
      run = (seg_in == sample_q) ? ({1'b0, cnt_q} + 9'd1) : 9'd1;
    end
  end

  // Next-state logic: debounce, digit shift-in and frame handshake.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    dcnt_d  = dcnt_q;
    value_d = value_q;
    blank_d = blank_q;
    err_d   = err_q;
    accept  = 1'b0;
    case (state_q)
      StCollect: begin
        cnt_d = run[7:0];
        if (run == 9'(STABLE_CYCLES)) begin
          accept  = 1'b1;
          // Clearing here makes a held pattern wait a full STABLE_CYCLES again.
          cnt_d   = 8'd0;
          value_d = (value_q << 4) | VW'(lk_nibble);
          blank_d = (blank_q << 1) | BW'(lk_blank);
          err_d   = err_q | lk_invalid;
          if (dcnt_q == DW'(DIGITS - 1)) begin
            state_d = StOutput;
          end else begin
            dcnt_d = dcnt_q + DW'(1);
          end
        end
      end
      StOutput: begin
        // Counting only resumes once back in collect, so a pattern held
        // through the transfer must re-qualify from scratch.
        cnt_d = 8'd0;
        if (value_ready) begin
          state_d = StCollect;
          dcnt_d  = '0;
          err_d   = 1'b0;
        end
      end
      default: begin
        state_d = StCollect;
        cnt_d   = 8'd0;
      end
    endcase
  end

  // State registers; the sample register resets to the blank pattern.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= StCollect;
      sample_q <= GLYPH_BLANK;
      cnt_q    <= 8'd0;
      dcnt_q   <= '0;
      value_q  <= '0;
      blank_q  <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      sample_q <= seg_in;
      cnt_q    <= cnt_d;
      dcnt_q   <= dcnt_d;
      value_q  <= value_d;
      blank_q  <= blank_d;
      err_q    <= err_d;
    end
  end

  // Output mapping.
  always_comb begin
    seg_ready   = accept;
    value       = value_q;
    blank_mask  = blank_q;
    value_valid = (state_q == StOutput);
    err         = err_q;
  end

endmodule

// File: tb/tb_seg7_capture.sv
// Self-checking bench for seg7_capture: directed scenarios followed by a
// randomized phase, all compared against a history-based reference model.
module tb_seg7_capture;

  localparam int unsigned STABLE = 4;
  localparam int unsigned NDIG   = 4;

  localparam logic [6:0] GLYPH_TAB [16] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
    7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
    7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
    7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
  };
  localparam logic [6:0] BLANK = 7'b1111111;

  logic              clk;
  logic              rst_n;
  logic [6:0]        seg_in;
  logic              seg_valid;
  logic              seg_ready;
  logic [4*NDIG-1:0] value;
  logic [NDIG-1:0]   blank_mask;
  logic              value_valid;
  logic              value_ready;
  logic              err;

  int checks   = 0;
  int failures = 0;

  seg7_capture #(
    .STABLE_CYCLES (STABLE),
    .DIGITS        (NDIG)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .seg_in      (seg_in),
    .seg_valid   (seg_valid),
    .seg_ready   (seg_ready),
    .value       (value),
    .blank_mask  (blank_mask),
    .value_valid (value_valid),
    .value_ready (value_ready),
    .err         (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: the samples seen since the last digit boundary, plus
  // the frame contents built from the specification's rules.
  typedef struct packed {
    logic       v;
    logic [6:0] s;
  } samp_t;

  samp_t             hist[$];
  logic              m_out;
  logic [4*NDIG-1:0] m_val;
  logic [NDIG-1:0]   m_blank;
  logic              m_err;
  int                m_n;

  function automatic void decode(input logic [6:0] p, output logic [3:0] nib,
                                 output logic bl, output logic inv);
    nib = 4'h0;
    bl  = 1'b0;
    inv = 1'b1;
    if (p == BLANK) begin
      bl  = 1'b1;
      inv = 1'b0;
    end else begin
      for (int i = 0; i < 16; i++) begin
        if (GLYPH_TAB[i] == p) begin
          nib = 4'(i);
          inv = 1'b0;
        end
      end
    end
  endfunction

  task automatic model_reset();
    hist.delete();
    m_out   = 1'b0;
    m_val   = '0;
    m_blank = '0;
    m_err   = 1'b0;
    m_n     = 0;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv)
    else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // One clock cycle: drive on the falling edge, compare shortly after, then
  // advance the model to what the next rising edge should produce.
  task automatic cycle(input logic [6:0] s, input logic v, input logic r);
    logic       exp_acc;
    logic [3:0] nib;
    logic       bl;
    logic       inv;
    @(negedge clk);
    seg_in      = s;
    seg_valid   = v;
    value_ready = r;
    #1;
    exp_acc = 1'b0;
    if (!m_out) begin
      hist.push_back({v, s});
      if (hist.size() > STABLE) void'(hist.pop_front());
      if (hist.size() == STABLE) begin
        exp_acc = 1'b1;
        foreach (hist[k]) begin
          if (!hist[k].v || hist[k].s != s) exp_acc = 1'b0;
        end
      end
    end
    chk("seg_ready", 32'(seg_ready), 32'(exp_acc));
    chk("value_valid", 32'(value_valid), 32'(m_out));
    chk("value", 32'(value), 32'(m_val));
    chk("blank_mask", 32'(blank_mask), 32'(m_blank));
    chk("err", 32'(err), 32'(m_err));
    if (exp_acc) begin
      decode(s, nib, bl, inv);
      m_val   = (m_val << 4) | (4 * NDIG)'(nib);
      m_blank = (m_blank << 1) | NDIG'(bl);
      m_err   = m_err | inv;
      m_n++;
      hist.delete();
      if (m_n == NDIG) m_out = 1'b1;
    end else if (m_out && r) begin
      m_out = 1'b0;
      m_err = 1'b0;
      m_n   = 0;
      hist.delete();
    end
  endtask

  task automatic hold(input logic [6:0] s, input int n, input logic r);
    for (int i = 0; i < n; i++) cycle(s, 1'b1, r);
  endtask

  // Pulse reset mid-cycle and confirm everything reads as cleared.
  task automatic do_reset();
    @(negedge clk);
    #2;
    rst_n       = 1'b0;
    seg_valid   = 1'b0;
    value_ready = 1'b0;
    #1;
    chk("rst_seg_ready", 32'(seg_ready), 32'd0);
    chk("rst_value", 32'(value), 32'd0);
    chk("rst_blank", 32'(blank_mask), 32'd0);
    chk("rst_valid", 32'(value_valid), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
  endtask

  // Sample registered outputs just after the edge that follows a hold.
  task automatic after_edge();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [6:0] pat;
    int         sel;
    int         len;
    rst_n       = 1'b0;
    seg_in      = BLANK;
    seg_valid   = 1'b0;
    value_ready = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    do_reset();

    // Single digit qualifies on its fourth valid cycle.
    hold(GLYPH_TAB[1], 4, 1'b0);
    after_edge();
    chk("d1_nibble", 32'(value[3:0]), 32'h1);
    // Complete the frame 1,2,blank,F.
    hold(GLYPH_TAB[2], 4, 1'b0);
    hold(BLANK, 4, 1'b0);
    hold(GLYPH_TAB[15], 4, 1'b0);
    after_edge();
    chk("f1_valid", 32'(value_valid), 32'd1);
    chk("f1_value", 32'(value), 32'h120F);
    chk("f1_blank", 32'(blank_mask), 32'b0010);
    chk("f1_err", 32'(err), 32'd0);

    // Consumer stalls with a steady new pattern on the bus.
    hold(GLYPH_TAB[3], 10, 1'b0);
    chk("stall_value", 32'(value), 32'h120F);
    cycle(GLYPH_TAB[3], 1'b1, 1'b1);
    hold(GLYPH_TAB[3], 4, 1'b0);
    after_edge();
    chk("post_xfer_nib", 32'(value[3:0]), 32'h3);
    chk("post_xfer_valid", 32'(value_valid), 32'd0);

    // Glitch: short-lived 3 (twice, here continuing the held 3) then 5.
    cycle(GLYPH_TAB[3], 1'b0, 1'b0);
    hold(GLYPH_TAB[3], 2, 1'b0);
    hold(GLYPH_TAB[5], 4, 1'b0);
    after_edge();
    chk("glitch_value", 32'(value[7:0]), 32'h35);

    // Unrecognised pattern inside a frame, then a digit 8.
    hold(7'b1010101, 4, 1'b0);
    hold(GLYPH_TAB[8], 4, 1'b1);
    after_edge();
    chk("inv_valid", 32'(value_valid), 32'd1);
    chk("inv_value", 32'(value), 32'h3508);
    chk("inv_err", 32'(err), 32'd1);
    cycle(BLANK, 1'b0, 1'b1);
    after_edge();
    chk("inv_err_clear", 32'(err), 32'd0);
    chk("inv_value_kept", 32'(value), 32'h3508);

    // Stray ready with no frame pending.
    hold(GLYPH_TAB[9], 3, 1'b1);

    // Reset after two digits discards the partial frame.
    hold(GLYPH_TAB[7], 4, 1'b0);
    hold(GLYPH_TAB[10], 4, 1'b0);
    do_reset();
    hold(GLYPH_TAB[11], 4, 1'b0);
    hold(GLYPH_TAB[12], 4, 1'b0);
    hold(GLYPH_TAB[13], 4, 1'b0);
    hold(GLYPH_TAB[14], 4, 1'b0);
    after_edge();
    chk("fresh_value", 32'(value), 32'hBCDE);
    chk("fresh_valid", 32'(value_valid), 32'd1);
    cycle(BLANK, 1'b1, 1'b1);

    // Randomized phase.
    for (int it = 0; it < 400; it++) begin
      sel = int'($urandom_range(0, 19));
      if (sel < 16) pat = GLYPH_TAB[sel];
      else if (sel < 18) pat = BLANK;
      else pat = 7'($urandom);
      len = int'($urandom_range(1, 6));
      for (int j = 0; j < len; j++) begin
        cycle(pat, ($urandom_range(0, 9) != 0), ($urandom_range(0, 2) == 0));
      end
      if ($urandom_range(0, 79) == 0) do_reset();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/seg7_capture.md
SEG7_CAPTURE -- requirements
Module: seg7_capture

Interface
REQ-001 SHALL have parameter STABLE_CYCLES, default 4, consecutive identical samples required to accept a pattern (legal range 2..255).
REQ-002 SHALL have parameter DIGITS, default 4, digits per captured frame.
REQ-003 SHALL use one clock and an asynchronous, active-low reset.
REQ-004 clk  input  1  rising-edge clock for all state.
REQ-005 rst_n  input  1  asynchronous active-low reset.
REQ-006 seg_in  input  7  active-low segment pattern, bit0=a .. bit6=g.
REQ-007 seg_valid  input  1  seg_in carries a driven pattern.
REQ-008 seg_ready  output  1  one-cycle pulse; high exactly in the cycle a digit is accepted.
REQ-009 value  output  4*DIGITS  captured hex value, first accepted digit in most-significant nibble.
REQ-010 blank_mask  output  DIGITS  bit i set when nibble i was a blank pattern.
REQ-011 value_valid  output  1  frame complete; value, blank_mask and err are stable.
REQ-012 value_ready  input  1  consumer accepts the frame.
REQ-013 err  output  1  frame contained at least one unrecognised pattern.

Function
REQ-014 Lookup SHALL map the 16 active-low hex glyphs (0: 1000000, 1: 1111001, 2: 0100100, 3: 0110000, 4: 0011001, 5: 0010010, 6: 0000010, 7: 1111000, 8: 0000000, 9: 0010000, A: 0001000, b: 0000011, C: 1000110, d: 0100001, E: 0000110, F: 0001110) to nibbles 0x0..0xF.
REQ-015 Pattern 1111111 SHALL decode as blank: nibble 0x0, blank bit 1.
REQ-016 Any other pattern SHALL decode as invalid: nibble 0x0, blank bit 0, err set.
REQ-017 FSM states SHALL be COLLECT and OUTPUT.
REQ-018 In COLLECT, the stability counter SHALL increment each cycle seg_valid=1 and seg_in equals the previous-cycle sample, and SHALL clear to 0 when seg_valid=0 or seg_in changes.
REQ-019 A digit SHALL be accepted (seg_ready=1) in the cycle the counter equals STABLE_CYCLES-1 and seg_in still matches; the counter then clears.
REQ-020 A held pattern SHALL be re-accepted only after another STABLE_CYCLES matching cycles.
REQ-021 Each accepted digit SHALL shift value left by 4 and insert the nibble at bits [3:0]; blank_mask shifts likewise.
REQ-022 On acceptance of digit DIGITS, the FSM SHALL enter OUTPUT and assert value_valid the next cycle.
REQ-023 In OUTPUT, seg_ready SHALL be 0, the counter SHALL be held at 0, and outputs SHALL hold until value_valid and value_ready are both 1.
REQ-024 On that transfer, the FSM SHALL return to COLLECT next cycle with value_valid=0, digit count 0 and err cleared; value and blank_mask keep their last contents until overwritten.
REQ-025 seg_in stable during the transfer cycle SHALL NOT be accepted; counting restarts from 0 in COLLECT.
REQ-026 value_ready while value_valid=0 SHALL have no effect.
REQ-027 err SHALL be sticky within a frame and reported with value_valid.

Reset
REQ-028 Reset SHALL set state COLLECT, value 0, blank_mask 0, value_valid 0, err 0, seg_ready 0, counter 0, digit count 0, sample register 1111111.
REQ-029 Reset mid-frame or mid-OUTPUT SHALL discard the partial or pending frame; no digit is accepted in the first cycle after release.

Structure
REQ-030 Package seg7_pkg SHALL hold the 17 glyph constants, the state enum and the STABLE_CYCLES default.
REQ-031 Combinational sub-module seg7_lookup (pattern -> nibble, blank, invalid) SHALL be instantiated once.

Verification
REQ-032 STABLE_CYCLES=4: seg_in 1111001 held valid 4 cycles -> seg_ready on the 4th cycle, nibble 0x1.
REQ-033 Digits 1,0x2 (0100100),blank,F (0001110) each held 4 cycles -> value=0x120F, blank_mask=0010, err=0, value_valid.
REQ-034 Glitch: pattern 3 for 2 cycles, then 5 for 4 cycles -> only 0x5 accepted.
REQ-035 Invalid pattern 1010101 in a frame -> nibble 0x0, err=1 with value_valid; err=0 after transfer.
REQ-036 value_ready low 10 cycles in OUTPUT with a stable new pattern -> value held, seg_ready 0; after transfer, new digit accepted 4 cycles later.
REQ-037 rst_n low after 2 digits -> all outputs 0; next frame captures 4 fresh digits.
